// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family (single- and dual-clock buffers).
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 32;
  localparam int MIN_DEPTH     = 2;
  localparam int MIN_MARGIN    = 0;

  // Occupancy runs 0..n inclusive, so it needs one more code than the depth.
  function automatic int cntWidth(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit depthOk(input int n);
    return n >= MIN_DEPTH;
  endfunction

  function automatic bit marginOk(input int n, input int margin);
    return (margin >= MIN_MARGIN) && (margin <= n - 1);
  endfunction

endpackage

// File: rtl/fifo_flagged_if.sv
// Producer/consumer handshake bundle for fifo_flagged; the FIFO takes the slave side.
interface fifo_flagged_if
  import fifo_pkg::*;
#(
  parameter int bitWidth    = DEFAULT_WIDTH,
  parameter int nrOfEntries = DEFAULT_DEPTH
);
  localparam int CNT_W = cntWidth(nrOfEntries);

  logic                push;
  logic [bitWidth-1:0] pushData;
  logic                pop;
  logic                clearErrors;
  logic [bitWidth-1:0] popData;
  logic                full;
  logic                empty;
  logic                almostFull;
  logic                almostEmpty;
  logic [CNT_W-1:0]    count;
  logic                overflow;
  logic                underflow;

  modport master (
    output push, pushData, pop, clearErrors,
    input  popData, full, empty, almostFull, almostEmpty, count, overflow, underflow
  );

  modport slave (
    input  push, pushData, pop, clearErrors,
    output popData, full, empty, almostFull, almostEmpty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_storage.sv
// Unreset storage array: synchronous write port, asynchronous read port.
module fifo_storage #(
  parameter int bitWidth    = 32,
  parameter int nrOfEntries = 16,
  parameter int addrW       = 4
) (
  input  logic                clock,
  input  logic                wrEn_i,
  input  logic [addrW-1:0]    wrAddr_i,
  input  logic [bitWidth-1:0] wrData_i,
  input  logic [addrW-1:0]    rdAddr_i,
  output logic [bitWidth-1:0] rdData_o
);

  logic [bitWidth-1:0] mem_q [nrOfEntries];

  always_ff @(posedge clock) begin
    if (wrEn_i) mem_q[wrAddr_i] <= wrData_i;
  end

  assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FWFT FIFO, any depth >= 2, with fill count, threshold flags and sticky error flags.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int nrOfEntries       = DEFAULT_DEPTH,
  parameter int bitWidth          = DEFAULT_WIDTH,
  parameter int almostFullMargin  = 2,
  parameter int almostEmptyMargin = 2
) (
  input  logic          clock,
  input  logic          reset,
  fifo_flagged_if.slave bus
);

  localparam int PTR_W = ptrWidth(nrOfEntries);
  localparam int CNT_W = cntWidth(nrOfEntries);

  generate
    if (!depthOk(nrOfEntries) || !marginOk(nrOfEntries, almostFullMargin) ||
        !marginOk(nrOfEntries, almostEmptyMargin)) begin : g_bad_cfg
      $error("fifo_flagged: depth must be >= 2 and margins within 0..depth-1");
    end
  endgenerate

  logic [PTR_W-1:0]    rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d, udf_q, udf_d;
  logic                full, empty, popAccept, pushAccept;
  logic [bitWidth-1:0] rdData;

  // Explicit wrap so non-power-of-two depths use every slot.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(nrOfEntries - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full       = (count_q == CNT_W'(nrOfEntries));
    empty      = (count_q == '0);
    popAccept  = bus.pop & ~empty;
    pushAccept = bus.push & (~full | popAccept);

    rdPtr_d = popAccept  ? ptrInc(rdPtr_q) : rdPtr_q;
    wrPtr_d = pushAccept ? ptrInc(wrPtr_q) : wrPtr_q;
    count_d = count_q + CNT_W'(pushAccept) - CNT_W'(popAccept);

    // Set beats clear when both happen on the same edge.
    ovf_d = (bus.push & ~pushAccept) | (ovf_q & ~bus.clearErrors);
    udf_d = (bus.pop & empty)        | (udf_q & ~bus.clearErrors);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_storage #(
    .bitWidth   (bitWidth),
    .nrOfEntries(nrOfEntries),
    .addrW      (PTR_W)
  ) u_storage (
    .clock   (clock),
    .wrEn_i  (pushAccept),
    .wrAddr_i(wrPtr_q),
    .wrData_i(bus.pushData),
    .rdAddr_i(rdPtr_q),
    .rdData_o(rdData)
  );

  assign bus.popData     = empty ? '0 : rdData;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostFull  = (count_q >= CNT_W'(nrOfEntries - almostFullMargin));
  assign bus.almostEmpty = (count_q <= CNT_W'(almostEmptyMargin));
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;

endmodule

// File: tb/tb_fifo_flagged.sv
// Scenario bench for fifo_flagged at depth 5 / width 8 / margins 1, with a queue scoreboard.
module tb_fifo_flagged;
  import fifo_pkg::*;

  localparam int N = 5;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_flagged_if #(.bitWidth(W), .nrOfEntries(N)) bus ();

  fifo_flagged #(
    .nrOfEntries(N), .bitWidth(W), .almostFullMargin(1), .almostEmptyMargin(1)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic exp_ovf = 1'b0;
  logic exp_udf = 1'b0;

  // {empty, full, almostEmpty, almostFull, overflow, underflow, count}
  function automatic logic [8:0] model_status();
    int n = exp_q.size();
    return {n == 0, n == N, n <= 1, n >= N - 1, exp_ovf, exp_udf, 3'(n)};
  endfunction

  function automatic logic [8:0] dut_status();
    return {bus.empty, bus.full, bus.almostEmpty, bus.almostFull,
            bus.overflow, bus.underflow, bus.count};
  endfunction

  function automatic logic [W-1:0] model_head();
    return (exp_q.size() == 0) ? '0 : exp_q[0];
  endfunction

  // Drives one cycle from a negedge, updates the scoreboard at the edge, returns at the next negedge.
  task automatic drive(input bit ps, input logic [W-1:0] d, input bit pp, input bit clr);
    bit pa, wa, was_full, was_empty;
    was_full  = (exp_q.size() == N);
    was_empty = (exp_q.size() == 0);
    pa = pp && !was_empty;
    wa = ps && (!was_full || pa);
    bus.push = ps; bus.pushData = d; bus.pop = pp; bus.clearErrors = clr;
    @(posedge clk);
    exp_ovf = (ps && !wa) ? 1'b1 : (clr ? 1'b0 : exp_ovf);
    exp_udf = (pp && was_empty) ? 1'b1 : (clr ? 1'b0 : exp_udf);
    if (pa) void'(exp_q.pop_front());
    if (wa) exp_q.push_back(d);
    @(negedge clk);
    bus.push = 1'b0; bus.pop = 1'b0; bus.clearErrors = 1'b0; bus.pushData = '0;
  endtask

  task automatic test_reset();
    bus.push = 1'b0; bus.pop = 1'b0; bus.clearErrors = 1'b0; bus.pushData = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) drive(0, '0, 0, 0);
    checks++;
    if (dut_status() !== 9'b1_0_1_0_0_0_000) begin
      errors++; $display("FAIL reset_status got %b want %b", dut_status(), 9'b101000000);
    end
    checks++;
    if (bus.popData !== 8'h00) begin
      errors++; $display("FAIL reset_popData got %h want 00", bus.popData);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) begin
      drive(1, 8'((i + 1) * 8'h11), 0, 0);
      checks++;
      if (bus.count !== 3'(i + 1) || dut_status() !== model_status()) begin
        errors++; $display("FAIL fill_status[%0d] got %b want %b", i, dut_status(), model_status());
      end
      checks++;
      if (bus.almostFull !== (i + 1 >= 4) || bus.full !== (i + 1 == 5)) begin
        errors++; $display("FAIL fill_flags[%0d] got aF=%b f=%b", i, bus.almostFull, bus.full);
      end
      checks++;
      if (bus.popData !== 8'h11) begin
        errors++; $display("FAIL fill_head[%0d] got %h want 11", i, bus.popData);
      end
    end
  endtask

  task automatic test_overflow();
    drive(1, 8'h66, 0, 0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 3'd5 || dut_status() !== model_status()) begin
      errors++; $display("FAIL overflow got %b want %b", dut_status(), model_status());
    end
    drive(1, 8'h77, 1, 0);
    checks++;
    if (bus.popData !== 8'h22 || bus.count !== 3'd5) begin
      errors++; $display("FAIL full_pushpop got data=%h cnt=%0d want 22/5", bus.popData, bus.count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.popData !== model_head()) begin
        errors++; $display("FAIL drain_data[%0d] got %h want %h", i, bus.popData, model_head());
      end
      drive(0, '0, 1, 0);
    end
    checks++;
    if (dut_status() !== model_status() || bus.empty !== 1'b1 || bus.popData !== 8'h00) begin
      errors++; $display("FAIL drain_empty got %b want %b", dut_status(), model_status());
    end
    drive(0, '0, 1, 0);
    checks++;
    if (bus.underflow !== 1'b1 || bus.count !== 3'd0 || dut_status() !== model_status()) begin
      errors++; $display("FAIL underflow got %b want %b", dut_status(), model_status());
    end
    drive(0, '0, 0, 1);
    checks++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL clear_errors got ovf=%b udf=%b want 0/0", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_pushpop_empty();
    drive(1, 8'hA5, 1, 0);
    checks++;
    if (bus.count !== 3'd1 || bus.underflow !== 1'b1 || bus.popData !== 8'hA5) begin
      errors++; $display("FAIL empty_pushpop got cnt=%0d udf=%b data=%h want 1/1/a5",
                         bus.count, bus.underflow, bus.popData);
    end
    drive(0, '0, 1, 1);
    checks++;
    if (dut_status() !== model_status()) begin
      errors++; $display("FAIL empty_pushpop_drain got %b want %b", dut_status(), model_status());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      bit ps = ($urandom_range(0, 3) != 0);
      bit pp = ($urandom_range(0, 2) != 0);
      checks++;
      if (bus.popData !== model_head()) begin
        errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, bus.popData, model_head());
      end
      drive(ps, 8'($urandom), pp, (i % 9) == 8);
      checks++;
      if (dut_status() !== model_status()) begin
        errors++; $display("FAIL b2b_status[%0d] got %b want %b", i, dut_status(), model_status());
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, '0, 0, 1);
    while (exp_q.size() > 0) drive(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 8'(8'h90 + i), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete(); exp_ovf = 1'b0; exp_udf = 1'b0;
    checks++;
    if (dut_status() !== 9'b1_0_1_0_0_0_000 || bus.popData !== 8'h00) begin
      errors++; $display("FAIL async_reset got %b data=%h want 101000000/00", dut_status(), bus.popData);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8'h3C, 0, 0);
    checks++;
    if (bus.popData !== 8'h3C || bus.count !== 3'd1) begin
      errors++; $display("FAIL post_reset got data=%h cnt=%0d want 3c/1", bus.popData, bus.count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_pushpop_empty();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
Next-generation synchronous FIFO with all nrOfEntries slots usable and support for any depth ≥ 2, including non-power-of-two depths.
- First-word-fall-through read port.
- Simultaneous push/pop in one cycle.
- Live fill count, almost-full and almost-empty thresholds.
- Sticky overflow and underflow error flags.
- Sits between producer/consumer pipelines as the standard elastic buffer.

Parameters:
nrOfEntries, 16, storage depth; any integer ≥ 2; all entries usable.
bitWidth, 32, data width in bits; ≥ 1.
almostFullMargin, 2, almostFull asserts when count ≥ nrOfEntries - almostFullMargin; range 0..nrOfEntries-1.
almostEmptyMargin, 2, almostEmpty asserts when count ≤ almostEmptyMargin; range 0..nrOfEntries-1.

Ports:
clock  in  1  single clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
push  in  1  write request.
pushData  in  bitWidth  write data; sampled on an accepted push.
pop  in  1  read request; consumes the word currently on popData.
clearErrors  in  1  synchronous clear of overflow and underflow.
popData  out  bitWidth  head-of-queue word; 0 while empty.
full  out  1  count == nrOfEntries.
empty  out  1  count == 0.
almostFull  out  1  threshold flag, see Parameters.
almostEmpty  out  1  threshold flag, see Parameters.
count  out  $clog2(nrOfEntries+1)  current occupancy.
overflow  out  1  sticky: a push was rejected.
underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (reset=0, asynchronous, no clock edge needed):
  - readPtr = writePtr = count = 0.
  - overflow = underflow = 0.
  - Outputs: empty=1, full=0, almostEmpty=1, almostFull=0 (given valid margins), popData=0.
  - Storage array is not reset.
- Flags are combinational from count; popData is combinational from storage[readPtr], forced to 0 while empty.
- popAccept = pop & !empty.
- pushAccept = push & (!full | popAccept). Push while full succeeds only if a pop is accepted in the same cycle.
- Rising edge, reset=1:
  - pushAccept: storage[writePtr] ← pushData; writePtr advances.
  - popAccept: readPtr advances.
  - count ← count + pushAccept - popAccept.
  - Push and pop both accepted: count unchanged, both pointers advance.
- Pointer wrap: at nrOfEntries-1 the pointer returns to 0. Explicit compare, no reliance on power-of-two overflow.
- Latency: a word pushed into an empty FIFO appears on popData and deasserts empty in the cycle after the accepting edge. There is no same-cycle bypass.
- Push and pop both asserted while empty: push accepted, pop rejected, underflow set, count becomes 1.
- Errors:
  - overflow ← 1 on any edge with push & !pushAccept.
  - underflow ← 1 on any edge with pop & empty.
  - Both are cleared by clearErrors=1 on an edge. If set and clear coincide, set wins.
  - Rejected requests never change pointers, count or storage.
- Reset mid-operation: contents are discarded immediately; the FIFO reads as empty on the next cycle after reset deasserts.
- Elaboration check: error if nrOfEntries < 2 or a margin is out of range.

Decomposition:
- Package fifo_pkg holds:
  - count-width function clog2(n+1);
  - margin range-check constants;
  - default width/depth constants shared with other buffers.
- Sub-module fifo_storage: bitWidth × nrOfEntries array, synchronous write (enable, address, data), asynchronous read address. It is reusable by later dual-clock variants.

Test Plan:
Each case uses nrOfEntries=5, bitWidth=8, both margins 1.
- Reset, then idle 3 cycles → empty=1, count=0, almostEmpty=1, popData=0, overflow=0, underflow=0.
- Push 0x11..0x55 on 5 consecutive edges → count 1,2,3,4,5; almostFull rises at count=4; full=1 at count=5; popData=0x11 from the cycle after the first push.
- From full, push 0x66 alone → rejected, overflow=1, count=5. Then push 0x77 with pop → popData becomes 0x22, count=5, 0x77 stored at slot 0 (wrap).
- Pop 5 times → data order 0x22,0x33,0x44,0x55,0x77, then empty=1. A 6th pop → underflow=1, count=0. Then pulse clearErrors → both flags 0.
- From empty, push 0xA5 with pop in the same cycle → count=1, underflow=1, popData=0xA5 next cycle.
- Three pushes, then assert reset low between clock edges → empty=1, count=0, popData=0 without waiting for an edge. After release, push 0x3C → popData=0x3C.
